bp_be_npc_redirect: RTL and testbench
=====================================

# bp_be_npc_redirect

Back-end next-PC tracker and redirect issuer; the consumer of the branch packets produced by the control pipe. It holds the architecturally expected next PC, updated by every resolved branch packet. Each instruction entering execute is compared against that expected PC; a mismatch raises a flush and issues a redirect command to the front-end command queue over a valid/ready handshake. The block then holds the flush until the front end reports the redirect complete.

## Interface
- vaddr_width_p, 39, virtual address width.
- reset_pc_p, 39'h00_8000_0000, expected-NPC value after reset.
- cnt_width_p, 16, mispredict counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- br_v_i  in  1  branch packet valid (pipe-level v, already flush-qualified).
- br_branch_i  in  1  packet came from a control-flow instruction.
- br_btaken_i  in  1  branch/jump resolved taken.
- br_npc_i  in  vaddr_width_p  resolved next PC.
- inst_v_i  in  1  instruction entering execute is valid.
- inst_pc_i  in  vaddr_width_p  PC of that instruction.
- flush_o  out  1  squash younger in-flight instructions.
- redirect_v_o  out  1  redirect command valid.
- redirect_ready_i  in  1  FE command queue accepts.
- redirect_npc_o  out  vaddr_width_p  PC to restart fetch.
- redirect_branch_o  out  1  redirect caused by a control-flow instruction.
- redirect_btaken_o  out  1  taken status of that instruction.
- fe_done_i  in  1  front end has applied the redirect.
- npc_o  out  vaddr_width_p  current expected NPC (npc_r).
- mispredict_cnt_o  out  cnt_width_p  saturating mispredict count.

## Operation
- Registers: state, npc_r, last_branch_r, last_btaken_r, redirect_npc_r, cnt_r.
- States:
  - e_run: normal operation.
  - e_send: redirect pending.
  - e_wait: waiting for the front end to apply the redirect.
- Packet acceptance: only in e_run; accepted when br_v_i=1.
  - Accepted packet: npc_r <= br_npc_i; last_branch_r <= br_branch_i; last_btaken_r <= br_btaken_i.
  - br_v_i in e_send or e_wait is ignored.
- Expected PC with bypass: exp_npc = br_v_i ? br_npc_i : npc_r. A packet and an instruction arriving in the same cycle compare the instruction against the packet's npc.
- Mismatch: e_run & inst_v_i & (inst_pc_i != exp_npc). Full vaddr_width_p compare, no masking. On mismatch:
  - redirect_npc_r <= exp_npc.
  - redirect_branch/btaken come from the same-cycle packet if br_v_i, else from last_*_r.
  - cnt_r increments, saturating at all-ones.
  - state goes to e_send.
- Transitions:
  - e_run -> e_send on mismatch.
  - e_send -> e_wait when redirect_v_o & redirect_ready_i.
  - e_wait -> e_run when fe_done_i.
  - fe_done_i outside e_wait is ignored.
- Outputs:
  - flush_o = (state != e_run), decoded from registered state only.
  - redirect_v_o = (state == e_send).
  - redirect_npc_o, redirect_branch_o, redirect_btaken_o are registered and stable while redirect_v_o=1.
- On return to e_run, npc_r equals redirect_npc_r. It was loaded at the mismatch and is frozen in non-run states.
- Reset (any cycle, including mid-redirect) clears:
  - state -> e_run; npc_r -> reset_pc_p; cnt_r -> 0.
  - redirect_v_o, flush_o, last_*, redirect_branch/btaken -> 0.
  - redirect_npc_r -> reset_pc_p.

## Timing
- All outputs are register-derived; no combinational path from any input to any output.
- Mismatch detected in cycle t: flush_o=1 and redirect_v_o=1 from t+1.
- Handshake at cycle h: redirect_v_o=0 at h+1. redirect_v_o never drops without ready.
- fe_done_i at cycle d in e_wait: flush_o=0 at d+1, and comparisons resume at d+1.
- Minimum flush window: 2 cycles (ready at t+1, done at t+2).
- Back-to-back mismatches are impossible: at most one redirect is outstanding.
- Counter saturates. Wrap-around of npc values is plain vaddr_width_p equality, with no special handling.

## Test plan
- Reset: assert reset_n_i=0 -> npc_o=39'h0080000000, flush_o=0, redirect_v_o=0, mispredict_cnt_o=0.
- Correct prediction: packet br_npc_i=0x80000010 at t, then inst_pc_i=0x80000010 at t+1 -> no flush; npc_o=0x80000010.
- Bypass mismatch: br_npc_i=0x80000100 (btaken=1, branch=1) and inst_pc_i=0x80000004 in the same cycle t -> at t+1: redirect_v_o=1, redirect_npc_o=0x80000100, redirect_btaken_o=1, flush_o=1, count=1.
- Backpressure: hold redirect_ready_i=0 for 5 cycles, with br_v_i pulses carrying npc=0x123 -> redirect_v_o and payload stay stable; npc_o unchanged. Ready=1 then fe_done_i=1 -> flush_o falls exactly one cycle after fe_done_i.
- Reset mid-redirect: drop reset_n_i while in e_wait -> outputs return to reset values immediately. After release, a matching inst_pc_i=0x80000000 causes no redirect.
- Saturation: with cnt_width_p=4, force 17 mispredicts -> mispredict_cnt_o holds at 15.

Source files
------------

// File: rtl/bp_be_npc_redirect.sv
// rtl/bp_be_npc_redirect.sv - back-end expected-NPC tracker and front-end redirect issuer
module bp_be_npc_redirect #(
  parameter int                       vaddr_width_p = 39,
  parameter logic [vaddr_width_p-1:0] reset_pc_p    = 39'h00_8000_0000,
  parameter int                       cnt_width_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     br_v_i,
  input  logic                     br_branch_i,
  input  logic                     br_btaken_i,
  input  logic [vaddr_width_p-1:0] br_npc_i,
  input  logic                     inst_v_i,
  input  logic [vaddr_width_p-1:0] inst_pc_i,
  output logic                     flush_o,
  output logic                     redirect_v_o,
  input  logic                     redirect_ready_i,
  output logic [vaddr_width_p-1:0] redirect_npc_o,
  output logic                     redirect_branch_o,
  output logic                     redirect_btaken_o,
  input  logic                     fe_done_i,
  output logic [vaddr_width_p-1:0] npc_o,
  output logic [cnt_width_p-1:0]   mispredict_cnt_o
);

  typedef enum logic [1:0] {
    e_run  = 2'd0,
    e_send = 2'd1,
    e_wait = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [vaddr_width_p-1:0] npc_q, npc_d;
  logic                     last_branch_q, last_branch_d;
  logic                     last_btaken_q, last_btaken_d;
  logic [vaddr_width_p-1:0] redirect_npc_q, redirect_npc_d;
  logic                     redirect_branch_q, redirect_branch_d;
  logic                     redirect_btaken_q, redirect_btaken_d;
  logic [cnt_width_p-1:0]   cnt_q, cnt_d;

  logic [vaddr_width_p-1:0] exp_npc;
  logic                     mismatch;

  // A packet arriving alongside an instruction is the newer truth, so it wins.
  assign exp_npc  = br_v_i ? br_npc_i : npc_q;
  assign mismatch = (state_q == e_run) & inst_v_i & (inst_pc_i != exp_npc);

  always_comb begin
    state_d           = state_q;
    npc_d             = npc_q;
    last_branch_d     = last_branch_q;
    last_btaken_d     = last_btaken_q;
    redirect_npc_d    = redirect_npc_q;
    redirect_branch_d = redirect_branch_q;
    redirect_btaken_d = redirect_btaken_q;
    cnt_d             = cnt_q;

    unique case (state_q)
      e_run: begin
        if (br_v_i) begin
          npc_d         = br_npc_i;
          last_branch_d = br_branch_i;
          last_btaken_d = br_btaken_i;
        end
        if (mismatch) begin
          redirect_npc_d    = exp_npc;
          redirect_branch_d = br_v_i ? br_branch_i : last_branch_q;
          redirect_btaken_d = br_v_i ? br_btaken_i : last_btaken_q;
          cnt_d             = (cnt_q == '1) ? cnt_q : cnt_q + cnt_width_p'(1);
          state_d           = e_send;
        end
      end
      e_send: begin
        if (redirect_ready_i) state_d = e_wait;
      end
      e_wait: begin
        if (fe_done_i) state_d = e_run;
      end
      default: state_d = e_run;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q           <= e_run;
      npc_q             <= reset_pc_p;
      last_branch_q     <= 1'b0;
      last_btaken_q     <= 1'b0;
      redirect_npc_q    <= reset_pc_p;
      redirect_branch_q <= 1'b0;
      redirect_btaken_q <= 1'b0;
      cnt_q             <= '0;
    end else begin
      state_q           <= state_d;
      npc_q             <= npc_d;
      last_branch_q     <= last_branch_d;
      last_btaken_q     <= last_btaken_d;
      redirect_npc_q    <= redirect_npc_d;
      redirect_branch_q <= redirect_branch_d;
      redirect_btaken_q <= redirect_btaken_d;
      cnt_q             <= cnt_d;
    end
  end

  assign flush_o           = (state_q != e_run);
  assign redirect_v_o      = (state_q == e_send);
  assign redirect_npc_o    = redirect_npc_q;
  assign redirect_branch_o = redirect_branch_q;
  assign redirect_btaken_o = redirect_btaken_q;
  assign npc_o             = npc_q;
  assign mispredict_cnt_o  = cnt_q;

endmodule

// File: tb/tb_bp_be_npc_redirect.sv
// tb/tb_bp_be_npc_redirect.sv - randomized and directed checks of bp_be_npc_redirect against a queue-based model
module tb_bp_be_npc_redirect;

  localparam int VW = 39;
  typedef logic [VW-1:0] vaddr_t;
  localparam vaddr_t RESET_PC = 39'h00_8000_0000;

  logic   clk = 1'b0;
  logic   reset_n;
  logic   br_v, br_branch, br_btaken;
  vaddr_t br_npc;
  logic   inst_v;
  vaddr_t inst_pc;
  logic   ready, fe_done;

  logic        flush, rv, rbranch, rbtaken;
  vaddr_t      rnpc, npc;
  logic [15:0] cnt;
  logic        flush_s, rv_s, rbranch_s, rbtaken_s;
  vaddr_t      rnpc_s, npc_s;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  bp_be_npc_redirect dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .br_v_i(br_v), .br_branch_i(br_branch), .br_btaken_i(br_btaken), .br_npc_i(br_npc),
    .inst_v_i(inst_v), .inst_pc_i(inst_pc),
    .flush_o(flush), .redirect_v_o(rv), .redirect_ready_i(ready),
    .redirect_npc_o(rnpc), .redirect_branch_o(rbranch), .redirect_btaken_o(rbtaken),
    .fe_done_i(fe_done), .npc_o(npc), .mispredict_cnt_o(cnt)
  );

  bp_be_npc_redirect #(.cnt_width_p(4)) dut_sat (
    .clk_i(clk), .reset_n_i(reset_n),
    .br_v_i(br_v), .br_branch_i(br_branch), .br_btaken_i(br_btaken), .br_npc_i(br_npc),
    .inst_v_i(inst_v), .inst_pc_i(inst_pc),
    .flush_o(flush_s), .redirect_v_o(rv_s), .redirect_ready_i(ready),
    .redirect_npc_o(rnpc_s), .redirect_branch_o(rbranch_s), .redirect_btaken_o(rbtaken_s),
    .fe_done_i(fe_done), .npc_o(npc_s), .mispredict_cnt_o(cnt_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: an outstanding-redirect queue (depth at most one) plus a "sent" flag.
  typedef struct {
    vaddr_t pc;
    logic   branch;
    logic   btaken;
  } redir_t;

  redir_t pend[$];
  logic   m_sent;
  vaddr_t m_npc;
  logic   m_lb, m_lt;
  int     m_cnt;

  task automatic model_reset();
    pend.delete();
    m_sent = 1'b0;
    m_npc  = RESET_PC;
    m_lb   = 1'b0;
    m_lt   = 1'b0;
    m_cnt  = 0;
  endtask

  function automatic vaddr_t expected_pc();
    return br_v ? br_npc : m_npc;
  endfunction

  task automatic model_step();
    redir_t r;
    vaddr_t e;
    if (pend.size() == 0) begin
      e = expected_pc();
      if (inst_v && inst_pc != e) begin
        r.pc     = e;
        r.branch = br_v ? br_branch : m_lb;
        r.btaken = br_v ? br_btaken : m_lt;
        pend.push_back(r);
        m_sent = 1'b0;
        m_cnt++;
      end
      if (br_v) begin
        m_npc = br_npc;
        m_lb  = br_branch;
        m_lt  = br_btaken;
      end
    end else if (!m_sent) begin
      if (ready) m_sent = 1'b1;
    end else if (fe_done) begin
      void'(pend.pop_front());
    end
  endtask

  task automatic check_all();
    logic busy, send;
    busy = (pend.size() != 0);
    send = busy && !m_sent;
    check("npc", npc, m_npc);
    check("flush", flush, busy);
    check("redirect_v", rv, send);
    check("cnt", cnt, (m_cnt > 65535) ? 65535 : m_cnt);
    check("cnt_sat", cnt_s, (m_cnt > 15) ? 15 : m_cnt);
    check("flush_sat_inst", flush_s, busy);
    if (send) begin
      check("redirect_npc", rnpc, pend[0].pc);
      check("redirect_branch", rbranch, pend[0].branch);
      check("redirect_btaken", rbtaken, pend[0].btaken);
    end
  endtask

  task automatic drive(input logic bv, input logic bb, input logic bt, input vaddr_t bn,
                       input logic iv, input vaddr_t ip, input logic rdy, input logic dn);
    br_v = bv; br_branch = bb; br_btaken = bt; br_npc = bn;
    inst_v = iv; inst_pc = ip; ready = rdy; fe_done = dn;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_npc", npc, 39'h0080000000);
    check("rst_flush", flush, 0);
    check("rst_rv", rv, 0);
    check("rst_cnt", cnt, 0);
    check("rst_rnpc", rnpc, RESET_PC);
    check("rst_rbtaken", rbtaken, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  function automatic vaddr_t rand_pc();
    return vaddr_t'({$urandom(), $urandom()});
  endfunction

  initial begin
    reset_n = 1'b1;
    idle();
    model_reset();
    do_reset();

    // Correct prediction
    drive(1, 1, 0, 39'h8000_0010, 0, '0, 0, 0); cycle();
    drive(0, 0, 0, '0, 1, 39'h8000_0010, 0, 0); cycle();
    check("ok_flush", flush, 0);
    check("ok_npc", npc, 39'h8000_0010);

    // Same-cycle packet and instruction: compare against the packet's npc
    drive(1, 1, 1, 39'h8000_0100, 1, 39'h8000_0004, 0, 0); cycle();
    check("byp_rv", rv, 1);
    check("byp_rnpc", rnpc, 39'h8000_0100);
    check("byp_btaken", rbtaken, 1);
    check("byp_flush", flush, 1);
    check("byp_cnt", cnt, 1);

    // Backpressure with ignored packets
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 1, 1, 39'h123, 1, 39'h777, 0, 1);
      cycle();
      check("bp_rv", rv, 1);
      check("bp_rnpc", rnpc, 39'h8000_0100);
      check("bp_npc", npc, 39'h8000_0100);
    end
    drive(0, 0, 0, '0, 0, '0, 1, 0); cycle();
    check("hs_rv", rv, 0);
    check("hs_flush", flush, 1);
    drive(0, 0, 0, '0, 0, '0, 0, 1); cycle();
    check("done_flush", flush, 0);

    // Reset while waiting for the front end
    drive(0, 0, 0, '0, 1, 39'h5, 0, 0); cycle();
    drive(0, 0, 0, '0, 0, '0, 1, 0); cycle();
    check("wait_flush", flush, 1);
    idle();
    do_reset();
    drive(0, 0, 0, '0, 1, 39'h8000_0000, 0, 0); cycle();
    drive(0, 0, 0, '0, 0, '0, 0, 0); cycle();
    check("post_rst_rv", rv, 0);
    check("post_rst_flush", flush, 0);

    // Force 17 mispredicts for counter saturation
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 0, '0, 1, ~m_npc, 0, 0); cycle();
      drive(0, 0, 0, '0, 0, '0, 1, 0); cycle();
      drive(0, 0, 0, '0, 0, '0, 0, 1); cycle();
    end
    check("sat_cnt", cnt_s, 15);
    check("nosat_cnt", cnt, 17);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic   bv, iv;
      vaddr_t bn, ip;
      bv = ($urandom_range(0, 2) == 0);
      bn = ($urandom_range(0, 3) == 0) ? rand_pc() : vaddr_t'(39'h8000_0000 + 4 * $urandom_range(0, 15));
      iv = ($urandom_range(0, 3) != 0);
      ip = bv ? bn : m_npc;
      if ($urandom_range(0, 5) == 0) ip = ip ^ (vaddr_t'(1) << $urandom_range(0, VW - 1));
      drive(bv, 1'($urandom), 1'($urandom), bn, iv, ip,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      cycle();
      if (i == 1000) begin
        idle();
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
